sr_latch: RTL and testbench

// - Clocked set/reset storage bank: WIDTH independent SR cells, each holding one bit
//   and driving complementary outputs q/qn.
// - Replaces free-running cross-coupled NOR latches with a synchronous, glitch-free

---
 rtl/sr_latch_if.sv | 23 ++
 rtl/sr_latch.sv | 78 +++++++
 tb/tb_sr_latch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_if.sv
// Set/reset request bus and cell outputs for the sr_latch storage bank.
interface sr_latch_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] invalid;
  logic             inv_stky;

  // Requester drives s/r and observes the cell state.
  modport master (
    output s, r,
    input  q, qn, invalid, inv_stky
  );

  // Storage bank consumes s/r and drives the cell state.
  modport slave (
    input  s, r,
    output q, qn, invalid, inv_stky
  );
endinterface : sr_latch_if

// File: rtl/sr_latch.sv
// Clocked SR storage bank: WIDTH independent set/reset cells with registered
// complementary outputs, per-cell invalid flag and a sticky invalid summary.
module sr_latch #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned INVALID_MODE = 0,  // 0 NOR-style, 1 reset-dominant, 2 set-dominant
  parameter bit          RESET_VAL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  sr_latch_if.slave  sr_if
);

  localparam logic [WIDTH-1:0] RST_Q = {WIDTH{RESET_VAL}};

  logic [WIDTH-1:0] q_d,   q_q;
  logic [WIDTH-1:0] qn_d,  qn_q;
  logic [WIDTH-1:0] inv_d, inv_q;
  logic             stky_d, stky_q;

  // Per-cell next state; qn is rebuilt from the stored bit on hold so a
  // NOR-style invalid cycle (q=qn=0) resolves cleanly to q=0/qn=1.
  always_comb begin
    q_d   = q_q;
    qn_d  = ~q_q;
    inv_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case ({sr_if.s[i], sr_if.r[i]})
        2'b10: begin
          q_d[i]  = 1'b1;
          qn_d[i] = 1'b0;
        end
        2'b01: begin
          q_d[i]  = 1'b0;
          qn_d[i] = 1'b1;
        end
        2'b11: begin
          inv_d[i] = 1'b1;
          if (INVALID_MODE == 32'd2) begin
            q_d[i]  = 1'b1;
            qn_d[i] = 1'b0;
          end else if (INVALID_MODE == 32'd1) begin
            q_d[i]  = 1'b0;
            qn_d[i] = 1'b1;
          end else begin
            q_d[i]  = 1'b0;
            qn_d[i] = 1'b0;
          end
        end
        default: begin
          q_d[i]  = q_q[i];
          qn_d[i] = ~q_q[i];
        end
      endcase
    end
    stky_d = stky_q | (|inv_d);
  end

  // State registers with asynchronous reset to the configured value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RST_Q;
      qn_q   <= ~RST_Q;
      inv_q  <= '0;
      stky_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      qn_q   <= qn_d;
      inv_q  <= inv_d;
      stky_q <= stky_d;
    end
  end

  assign sr_if.q        = q_q;
  assign sr_if.qn       = qn_q;
  assign sr_if.invalid  = inv_q;
  assign sr_if.inv_stky = stky_q;

endmodule : sr_latch

// File: tb/tb_sr_latch.sv
// Self-checking bench for sr_latch: four configurations driven in lockstep,
// directed scenarios followed by random s/r with random async reset pulses.
module tb_sr_latch;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sr_latch_if #(.WIDTH(1)) if0 ();
  sr_latch_if #(.WIDTH(1)) if1 ();
  sr_latch_if #(.WIDTH(4)) if2 ();
  sr_latch_if #(.WIDTH(4)) if3 ();

  sr_latch #(.WIDTH(1), .INVALID_MODE(0), .RESET_VAL(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .sr_if(if0));
  sr_latch #(.WIDTH(1), .INVALID_MODE(2), .RESET_VAL(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .sr_if(if1));
  sr_latch #(.WIDTH(4), .INVALID_MODE(0), .RESET_VAL(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .sr_if(if2));
  sr_latch #(.WIDTH(4), .INVALID_MODE(1), .RESET_VAL(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .sr_if(if3));

  // Configuration of each instance, as seen by the reference model.
  int   cfg_w    [4] = '{1, 1, 4, 4};
  int   cfg_mode [4] = '{0, 2, 0, 1};
  bit   cfg_rv   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Stimulus per instance (only the low cfg_w bits are used).
  logic [3:0] sv [4];
  logic [3:0] rv [4];

  // Reference model: remembered bit per cell plus expected visible outputs.
  bit   m_bit  [4][4];
  bit   m_q    [4][4];
  bit   m_qn   [4][4];
  bit   m_inv  [4][4];
  bit   m_stky [4];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [3:0] pack(input int k, input int which);
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < cfg_w[k]; i++) begin
      case (which)
        0:       v[i] = m_q[k][i];
        1:       v[i] = m_qn[k][i];
        default: v[i] = m_inv[k][i];
      endcase
    end
    return v;
  endfunction

  task automatic get_obs(input int k, output logic [3:0] q, output logic [3:0] qn,
                         output logic [3:0] inv, output logic stky);
    case (k)
      0: begin q = 4'(if0.q); qn = 4'(if0.qn); inv = 4'(if0.invalid); stky = if0.inv_stky; end
      1: begin q = 4'(if1.q); qn = 4'(if1.qn); inv = 4'(if1.invalid); stky = if1.inv_stky; end
      2: begin q = if2.q;     qn = if2.qn;     inv = if2.invalid;     stky = if2.inv_stky; end
      default: begin q = if3.q; qn = if3.qn; inv = if3.invalid; stky = if3.inv_stky; end
    endcase
  endtask

  task automatic check_all(input string phase);
    logic [3:0] q, qn, inv;
    logic       stky;
    for (int k = 0; k < 4; k++) begin
      get_obs(k, q, qn, inv, stky);
      check($sformatf("%s u%0d q", phase, k),       q,   pack(k, 0));
      check($sformatf("%s u%0d qn", phase, k),      qn,  pack(k, 1));
      check($sformatf("%s u%0d invalid", phase, k), inv, pack(k, 2));
      check($sformatf("%s u%0d inv_stky", phase, k), 4'(stky), 4'(m_stky[k]));
    end
  endtask

  // Reset behaviour: every cell takes the configured value, flags clear.
  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_stky[k] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_bit[k][i] = cfg_rv[k];
        m_q[k][i]   = cfg_rv[k];
        m_qn[k][i]  = !cfg_rv[k];
        m_inv[k][i] = 1'b0;
      end
    end
  endfunction

  // One clock edge of the rules: hold / set / reset / invalid per mode.
  function automatic void model_edge();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < cfg_w[k]; i++) begin
        m_inv[k][i] = 1'b0;
        if (sv[k][i] && rv[k][i]) begin
          m_inv[k][i] = 1'b1;
          m_stky[k]   = 1'b1;
          if (cfg_mode[k] == 2) m_bit[k][i] = 1'b1;
          else                  m_bit[k][i] = 1'b0;
        end else if (sv[k][i]) begin
          m_bit[k][i] = 1'b1;
        end else if (rv[k][i]) begin
          m_bit[k][i] = 1'b0;
        end
        m_q[k][i]  = m_bit[k][i];
        m_qn[k][i] = !m_bit[k][i];
        if (m_inv[k][i] && cfg_mode[k] == 0) m_qn[k][i] = 1'b0;
      end
    end
  endfunction

  task automatic apply();
    if0.s = sv[0][0]; if0.r = rv[0][0];
    if1.s = sv[1][0]; if1.r = rv[1][0];
    if2.s = sv[2];    if2.r = rv[2];
    if3.s = sv[3];    if3.r = rv[3];
  endtask

  task automatic set_all(input logic [3:0] s, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      sv[k] = s;
      rv[k] = r;
    end
  endtask

  // Drive, clock, update the model, check one time unit after the edge.
  task automatic step(input string phase);
    apply();
    @(posedge clk);
    model_edge();
    #1;
    check_all(phase);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset_pulse(input string phase);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(phase);
    set_all(4'b0000, 4'b0000);
    apply();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    set_all(4'b0000, 4'b0000);
    apply();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");

    // Release with s=0 r=1
    @(negedge clk);
    rst_n = 1'b1;
    set_all(4'b0000, 4'b0001);
    step("release_r");

    // Set then hold for 3 cycles
    set_all(4'b0001, 4'b0000);
    step("set");
    set_all(4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) step("set_hold");

    // Reset then hold
    set_all(4'b0000, 4'b0001);
    step("reset");
    set_all(4'b0000, 4'b0000);
    step("reset_hold");

    // Invalid then reset
    set_all(4'b0001, 4'b0001);
    step("invalid");
    set_all(4'b0000, 4'b0001);
    step("invalid_then_r");

    // Invalid then hold (NOR-style resolves to q=0/qn=1; set-dominant stays 1)
    set_all(4'b0001, 4'b0001);
    step("invalid2");
    set_all(4'b0000, 4'b0000);
    step("invalid_then_hold");
    step("invalid_hold2");

    // Multi-cell pattern: per-cell set/reset/invalid/hold in one edge
    async_reset_pulse("pre_multi");
    set_all(4'b0101, 4'b0011);
    step("multi");
    set_all(4'b0000, 4'b0000);
    step("multi_hold");

    // Requests held high across several edges
    set_all(4'b1111, 4'b0000);
    step("s_held");
    step("s_held2");
    set_all(4'b0000, 4'b1111);
    step("r_held");
    step("r_held2");

    // Async reset mid-cycle with outputs set
    set_all(4'b1111, 4'b0000);
    step("pre_async");
    async_reset_pulse("async_mid");
    set_all(4'b0000, 4'b0000);
    step("post_async_hold");

    // Randomized traffic with occasional async reset
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++) begin
        sv[k] = 4'($urandom);
        rv[k] = 4'($urandom);
      end
      step("rand");
      if ($urandom_range(0, 39) == 0) async_reset_pulse("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sr_latch
